// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Brief    : Per-button 2-flop synchronizer and debounce, followed by a
//             press arbiter that emits one single-cycle one-hot pulse per
//             accepted press. A press of more than one button from IDLE
//             raises a one-cycle multi_err pulse instead.
//  Config   : BTN_COND_SYNC_EN - when defined, a 2-flop synchronizer sits in
//             front of the debouncer. When undefined, btn_raw feeds the
//             debouncer directly, for inputs that are already synchronous.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int NBTN            = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] btn_held,
    output logic            multi_err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_HELD    = 2'd1;
    localparam logic [1:0] c_ST_LOCKOUT = 2'd2;

    logic [NBTN-1:0] w_samp;
    logic [NBTN-1:0] r_stable;
    logic [1:0]      r_state;
    logic            w_any;
    logic            w_onehot;

`ifdef BTN_COND_SYNC_EN
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;

    // Two-stage synchronizer bringing the asynchronous pins into clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp = r_sync2;
`else
    assign w_samp = btn_raw;
`endif

    // Independent debounce counter per button; a level change is accepted
    // only after DEBOUNCE_CYCLES consecutive differing samples.
    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_debounce
            logic [CW-1:0] r_cnt;

            // Count differing samples, restart on any return to the old level.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt        <= '0;
                    r_stable[gi] <= 1'b0;
                end else if (w_samp[gi] == r_stable[gi]) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_stable[gi] <= w_samp[gi];
                    r_cnt        <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    // The stable register is itself a flop, so it is exported directly.
    assign btn_held = r_stable;

    assign w_any    = |r_stable;
    assign w_onehot = w_any && ((r_stable & (r_stable - 1'b1)) == '0);

    // Press arbiter with registered single-cycle outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            btn       <= '0;
            multi_err <= 1'b0;
        end else begin
            btn       <= '0;
            multi_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_onehot) begin
                        btn     <= r_stable;
                        r_state <= c_ST_HELD;
                    end else if (w_any) begin
                        multi_err <= 1'b1;
                        r_state   <= c_ST_LOCKOUT;
                    end
                end
                c_ST_HELD: begin
                    if (!w_any) r_state <= c_ST_IDLE;
                end
                c_ST_LOCKOUT: begin
                    if (!w_any) r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Brief    : Directed self-checking bench for button_conditioner with
//             DEBOUNCE_CYCLES=4. Latency follows BTN_COND_SYNC_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int NBTN = 4;
    localparam int DEB  = 4;
`ifdef BTN_COND_SYNC_EN
    localparam int LAT  = DEB + 3;   // edge of the btn pulse
`else
    localparam int LAT  = DEB + 1;
`endif
    localparam int HLAT = LAT - 1;   // edge where btn_held changes

    logic            clk = 1'b0;
    logic            reset;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn;
    logic [NBTN-1:0] btn_held;
    logic            multi_err;

    int errors = 0;
    int checks = 0;
    int pulses;

    button_conditioner #(
        .NBTN            (NBTN),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn       (btn),
        .btn_held  (btn_held),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_btn,
                           input logic [3:0] e_held, input logic e_err);
        chk({tag, ".btn"},       32'(btn),       32'(e_btn));
        chk({tag, ".btn_held"},  32'(btn_held),  32'(e_held));
        chk({tag, ".multi_err"}, 32'(multi_err), 32'(e_err));
    endtask

    // Drop all buttons and let the debouncer and arbiter return to IDLE.
    task automatic release_all(input string tag);
        btn_raw = 4'b0000;
        for (int e = 1; e <= LAT + 3; e++) step();
        chk_out(tag, 4'b0000, 4'b0000, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 4'b0000;
        step();
        step();
        chk_out("reset", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        step();
        chk_out("idle", 4'b0000, 4'b0000, 1'b0);

        // 1. Clean press of button 1, then release.
        btn_raw = 4'b0010;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk_out($sformatf("t1.press.e%0d", e),
                    (e == LAT) ? 4'b0010 : 4'b0000,
                    (e >= HLAT) ? 4'b0010 : 4'b0000, 1'b0);
        end
        btn_raw = 4'b0000;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk_out($sformatf("t1.rel.e%0d", e), 4'b0000,
                    (e < HLAT) ? 4'b0010 : 4'b0000, 1'b0);
        end

        // 2. Bouncing input: 3 cycles high, 1 low, never qualifies.
        for (int e = 0; e < 20; e++) begin
            btn_raw = ((e % 4) == 3) ? 4'b0000 : 4'b0100;
            step();
            chk_out($sformatf("t2.bounce.e%0d", e), 4'b0000, 4'b0000, 1'b0);
        end
        release_all("t2.settle");

        // 3. Dual press locks out, then a clean single press after release.
        btn_raw = 4'b0101;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk_out($sformatf("t3.dual.e%0d", e), 4'b0000,
                    (e >= HLAT) ? 4'b0101 : 4'b0000, (e == LAT) ? 1'b1 : 1'b0);
        end
        release_all("t3.rel");
        btn_raw = 4'b1000;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk_out($sformatf("t3.single.e%0d", e),
                    (e == LAT) ? 4'b1000 : 4'b0000,
                    (e >= HLAT) ? 4'b1000 : 4'b0000, 1'b0);
        end
        release_all("t3.rel2");

        // 4. Adding a button while one is held gives no second pulse.
        btn_raw = 4'b0001;
        for (int e = 1; e <= LAT + 3; e++) begin
            step();
            chk($sformatf("t4.first.e%0d", e), 32'(btn),
                (e == LAT) ? 32'h1 : 32'h0);
        end
        btn_raw = 4'b0011;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk_out($sformatf("t4.add.e%0d", e), 4'b0000,
                    (e >= HLAT) ? 4'b0011 : 4'b0001, 1'b0);
        end
        release_all("t4.rel");
        btn_raw = 4'b0010;
        pulses  = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (btn != 4'b0000) pulses++;
            chk($sformatf("t4.second.e%0d", e), 32'(btn),
                (e == LAT) ? 32'h2 : 32'h0);
        end
        chk("t4.pulse_count", 32'(pulses), 32'd1);
        release_all("t4.rel2");

        // 5. Reset on edge 4 of a debounce; the held button re-qualifies.
        btn_raw = 4'b0001;
        for (int e = 1; e <= 3; e++) step();
        reset = 1'b1;
        step();
        chk_out("t5.in_reset", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= LAT + 2; e++) begin
            step();
            chk_out($sformatf("t5.after.e%0d", e),
                    (e == LAT) ? 4'b0001 : 4'b0000,
                    (e >= HLAT) ? 4'b0001 : 4'b0000, 1'b0);
        end
        release_all("t5.rel");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
